// File: rtl/imm_encoder_if.sv
// Handshake bundle for the immediate encoder: value request in, encoded result out.
// The master side is the requester/consumer; the slave side is the encoder.
interface imm_encoder_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      value;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      imm;
  logic [1:0]       eop;
  logic             found;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output in_valid, value, out_ready,
    input  in_ready, out_valid, imm, eop, found, miss_cnt
  );

  modport slave (
    input  in_valid, value, out_ready,
    output in_ready, out_valid, imm, eop, found, miss_cnt
  );
endinterface

// File: rtl/imm_encoder.sv
// Finds the lowest extension op and 16-bit immediate that the immediate extender
// would expand back into a given 32-bit constant, trying one op per cycle.
//
// state | meaning
// IDLE  | ready for a new constant
// TRY   | testing extension op 'mode' against the latched constant
// DONE  | result held until the consumer takes it
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRY  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      val_q, val_d;
  logic [15:0]      imm_q, imm_d;
  logic [1:0]       eop_q, eop_d;
  logic             found_q, found_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic             fit;
  logic [15:0]      cand;

  // Fit test and candidate immediate for the op currently being tried.
  always_comb begin
    fit  = 1'b0;
    cand = 16'h0000;
    case (mode_q)
      2'd0: begin
        fit  = (&val_q[31:15]) | ~(|val_q[31:15]);
        cand = val_q[15:0];
      end
      2'd1: begin
        fit  = ~(|val_q[31:16]);
        cand = val_q[15:0];
      end
      2'd2: begin
        fit  = ~(|val_q[15:0]);
        cand = val_q[31:16];
      end
      default: begin
        fit  = ~(|val_q[1:0]) & ((&val_q[31:17]) | ~(|val_q[31:17]));
        cand = val_q[17:2];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    val_d   = val_q;
    imm_d   = imm_q;
    eop_d   = eop_q;
    found_d = found_q;
    miss_d  = miss_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          val_d   = bus.value;
          mode_d  = 2'd0;
          state_d = TRY;
        end
      end
      TRY: begin
        if (fit) begin
          imm_d   = cand;
          eop_d   = mode_q;
          found_d = 1'b1;
          state_d = DONE;
        end else if (mode_q != 2'd3) begin
          mode_d = mode_q + 2'd1;
        end else begin
          imm_d   = 16'h0000;
          eop_d   = 2'd0;
          found_d = 1'b0;
          if (miss_q != {CNT_W{1'b1}}) begin
            miss_d = miss_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      val_q   <= 32'h0000_0000;
      imm_q   <= 16'h0000;
      eop_q   <= 2'd0;
      found_q <= 1'b0;
      miss_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      imm_q   <= imm_d;
      eop_q   <= eop_d;
      found_q <= found_d;
      miss_q  <= miss_d;
    end
  end

  // Handshake outputs come straight from state, so no input-to-output path exists.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.imm       = imm_q;
  assign bus.eop       = eop_q;
  assign bus.found     = found_q;
  assign bus.miss_cnt  = miss_q;

endmodule
